ex_mem_pipe_reg: RTL and testbench
==================================

Name: ex_mem_pipe_reg

Overview:
- Parametrised EX→MEM pipeline boundary; successor to the fixed three-FU-plus-LSU register.
- NCH independent channels, one per FU/LSU. Each channel is a 2-entry elastic stage (main + skid) with valid/ready handshake, back-pressure and global flush.
- Sits between the functional-unit outputs and the MEM/writeback stage.
- Per-channel order is preserved; channels never interact except through the shared flush.

Parameters:
- NCH, 4, number of channels (≥1).
- XLEN, 32, result and PC width.
- TAG_W, 6, ROB tag width.
- OP_W, 4, opcode field width.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all channels (mispredict/exception).
- in_valid  in  NCH  per-channel upstream valid.
- in_ready  out  NCH  per-channel upstream ready (registered).
- in_result  in  NCH*XLEN  result; channel i at [i*XLEN +: XLEN].
- in_pc  in  NCH*XLEN  instruction PC.
- in_tag  in  NCH*TAG_W  ROB tag.
- in_op  in  NCH*OP_W  opcode.
- in_mem_wr  in  NCH  store flag.
- in_mem_rd  in  NCH  load flag.
- out_valid  out  NCH  per-channel downstream valid.
- out_ready  in  NCH  per-channel downstream ready.
- out_result, out_pc, out_tag, out_op, out_mem_wr, out_mem_rd  out  same widths as inputs  registered payload.
- busy  out  1  OR of all channel valid bits (main or skid).

Behaviour:
- Reset (rstn=0, async): all valid bits 0, all payload registers 0, in_ready all 1, out_valid all 0, busy 0. Reset mid-transfer discards everything; no partial state survives.
- Per channel: main slot M (drives outputs), skid slot S.
  - in_ready = !S_valid, taken from a flop; no combinational in_valid→in_ready or out_ready→in_ready path.
  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
  - out_valid = M_valid; out_* = M payload.
- Transitions, per channel per edge, when flush=0:
  - M empty: accept loads M. Latency 1 cycle input→output.
  - M full, pop, S empty: accept loads M, otherwise M becomes empty.
  - M full, pop, S full: S moves to M, S empties, in_ready rises next cycle.
  - M full, no pop, S empty: accept loads S, in_ready drops next cycle.
  - M full, no pop, S full: hold; in_ready is 0, so no accept.
- Simultaneous accept and pop with M full and S empty: throughput is 1/cycle with no bubble.
- Payload hold:
  - Payload registers load only on write and are not cleared when a slot empties.
  - out_* are don't-care while out_valid=0, but stay stable (no toggling).
  - While out_valid=1 and out_ready=0, out_* are held bit-stable.
- flush=1:
  - Next edge: all M_valid and S_valid cleared, in_ready all 1.
  - Accepts and pops in the flush cycle are discarded; upstream must treat the accept as killed.
  - Payload registers are untouched.
  - flush has priority over every other transition.
- Channels are fully independent: a stall on channel i never affects channel j≠i.
- busy = |(M_valid | S_valid) over all channels, combinational from flops.
- Width rules: no arithmetic; pure transport. Field slices are fixed by the per-channel offsets given in Ports.

Decomposition:
- Shared package ex_mem_pkg holds:
  - default XLEN, TAG_W, OP_W;
  - a packed payload struct {result, pc, tag, op, mem_wr, mem_rd};
  - a PL_W localparam for its width.
- One sub-module is natural: ex_mem_skid_slot. It is a single-channel 2-entry elastic buffer on the packed payload, with in/out valid/ready and flush.
- Top instantiates NCH copies via generate, packs/unpacks the buses and ORs busy.

Test Plan:
- Reset with in_valid all 1 → out_valid=0, in_ready=4'b1111, out_* =0, busy=0. Release rstn, drive ch0 result 32'hDEAD_BEEF, tag 5 → next cycle out_valid[0]=1, out_result[0]=DEADBEEF, out_tag=5.
- Streaming: ch1 in_valid and out_ready held 1 for 8 cycles, PCs 0x100..0x11C → 8 outputs in order, one per cycle, in_ready[1] never drops.
- Back-pressure: ch2 out_ready=0, push A=0x11, B=0x22 → in_ready[2]=0 after B; C=0x33 held valid. Raise out_ready → outputs 11, 22, 33 in order, none lost or duplicated, out_result stable while stalled.
- Flush with M and S full on ch0 and ch3 and a concurrent accept → next cycle out_valid=0, in_ready=1111, busy=0; the flush-cycle input never appears.
- Independence: ch0 stalled (out_ready=0, S full) while ch1 streams 4 items → ch1 delivers all 4 on time; ch0 output unchanged.
- Async reset asserted mid-cycle with traffic in flight → outputs go to reset values immediately, without waiting for clk; first post-reset accept has latency 1.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared defaults and the per-channel payload carried across the EX->MEM boundary.
package ex_mem_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_TAG_W = 6;
  localparam int DEF_OP_W  = 4;

  typedef struct packed {
    logic [DEF_XLEN-1:0]  result;
    logic [DEF_XLEN-1:0]  pc;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_OP_W-1:0]  op;
    logic                 mem_wr;
    logic                 mem_rd;
  } ex_mem_payload_t;

  localparam int PL_W = $bits(ex_mem_payload_t);

endpackage

// File: rtl/ex_mem_skid_slot.sv
// Single-channel 2-entry elastic stage: main slot drives the outputs, skid slot
// absorbs the one beat that arrives while the main slot is stalled.
module ex_mem_skid_slot
  import ex_mem_pkg::*;
#(
  parameter type payload_t = ex_mem_payload_t
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     flush,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_data,
  output logic     busy
);

  logic     m_valid;
  logic     s_valid;
  payload_t m_data;
  payload_t s_data;
  logic     accept;
  logic     pop;

  // in_ready depends only on the skid flop, so no combinational path from
  // in_valid or out_ready reaches upstream.
  assign in_ready  = ~s_valid;
  assign accept    = in_valid & ~s_valid;
  assign pop       = m_valid & out_ready;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign busy      = m_valid | s_valid;

  // NOTE: all state uses non-blocking assignments so every slot samples the
  // pre-edge values of its neighbours; blocking here would make S->M ordering
  // depend on statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      // NOTE: payload registers are reset too, so no stale data from before a
      // reset is ever observable on the outputs.
      m_data  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid) begin
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= in_data;
      end
    end else if (pop) begin
      if (s_valid) begin
        m_data  <= s_data;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_data <= in_data;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_valid <= 1'b1;
      s_data  <= in_data;
    end
  end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline boundary: NCH independent elastic channels sharing only flush.
module ex_mem_pipe_reg
  import ex_mem_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int XLEN  = DEF_XLEN,
  parameter int TAG_W = DEF_TAG_W,
  parameter int OP_W  = DEF_OP_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  input  logic [NCH*XLEN-1:0]   in_result,
  input  logic [NCH*XLEN-1:0]   in_pc,
  input  logic [NCH*TAG_W-1:0]  in_tag,
  input  logic [NCH*OP_W-1:0]   in_op,
  input  logic [NCH-1:0]        in_mem_wr,
  input  logic [NCH-1:0]        in_mem_rd,
  output logic [NCH-1:0]        out_valid,
  input  logic [NCH-1:0]        out_ready,
  output logic [NCH*XLEN-1:0]   out_result,
  output logic [NCH*XLEN-1:0]   out_pc,
  output logic [NCH*TAG_W-1:0]  out_tag,
  output logic [NCH*OP_W-1:0]   out_op,
  output logic [NCH-1:0]        out_mem_wr,
  output logic [NCH-1:0]        out_mem_rd,
  output logic                  busy
);

  // Same field order as ex_mem_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  pc;
    logic [TAG_W-1:0] tag;
    logic [OP_W-1:0]  op;
    logic             mem_wr;
    logic             mem_rd;
  } payload_t;

  logic [NCH-1:0] ch_busy;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    payload_t in_pl;
    payload_t out_pl;

    assign in_pl = {in_result[i*XLEN +: XLEN], in_pc[i*XLEN +: XLEN],
                    in_tag[i*TAG_W +: TAG_W], in_op[i*OP_W +: OP_W],
                    in_mem_wr[i], in_mem_rd[i]};

    ex_mem_skid_slot #(.payload_t(payload_t)) u_slot (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .in_valid  (in_valid[i]),
      .in_ready  (in_ready[i]),
      .in_data   (in_pl),
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i]),
      .out_data  (out_pl),
      .busy      (ch_busy[i])
    );

    assign out_result[i*XLEN +: XLEN]  = out_pl.result;
    assign out_pc[i*XLEN +: XLEN]      = out_pl.pc;
    assign out_tag[i*TAG_W +: TAG_W]   = out_pl.tag;
    assign out_op[i*OP_W +: OP_W]      = out_pl.op;
    assign out_mem_wr[i]               = out_pl.mem_wr;
    assign out_mem_rd[i]               = out_pl.mem_rd;
  end

  assign busy = |ch_busy;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg with a per-channel FIFO scoreboard.
module tb_ex_mem_pipe_reg;
  import ex_mem_pkg::*;

  localparam int NCH   = 4;
  localparam int XLEN  = DEF_XLEN;
  localparam int TAG_W = DEF_TAG_W;
  localparam int OP_W  = DEF_OP_W;

  logic                 clk;
  logic                 rstn;
  logic                 flush;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [NCH*XLEN-1:0]  in_result;
  logic [NCH*XLEN-1:0]  in_pc;
  logic [NCH*TAG_W-1:0] in_tag;
  logic [NCH*OP_W-1:0]  in_op;
  logic [NCH-1:0]       in_mem_wr;
  logic [NCH-1:0]       in_mem_rd;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic [NCH*XLEN-1:0]  out_result;
  logic [NCH*XLEN-1:0]  out_pc;
  logic [NCH*TAG_W-1:0] out_tag;
  logic [NCH*OP_W-1:0]  out_op;
  logic [NCH-1:0]       out_mem_wr;
  logic [NCH-1:0]       out_mem_rd;
  logic                 busy;

  ex_mem_payload_t drv [NCH];
  ex_mem_payload_t sb  [NCH][$];
  int              pops [NCH];
  int              vectors;
  int              miscompares;

  ex_mem_pipe_reg #(.NCH(NCH), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_pc(in_pc), .in_tag(in_tag), .in_op(in_op),
    .in_mem_wr(in_mem_wr), .in_mem_rd(in_mem_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_pc(out_pc), .out_tag(out_tag), .out_op(out_op),
    .out_mem_wr(out_mem_wr), .out_mem_rd(out_mem_rd),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    in_result = '0;
    in_pc     = '0;
    in_tag    = '0;
    in_op     = '0;
    in_mem_wr = '0;
    in_mem_rd = '0;
    for (int i = 0; i < NCH; i++) begin
      in_result[i*XLEN +: XLEN]  = drv[i].result;
      in_pc[i*XLEN +: XLEN]      = drv[i].pc;
      in_tag[i*TAG_W +: TAG_W]   = drv[i].tag;
      in_op[i*OP_W +: OP_W]      = drv[i].op;
      in_mem_wr[i]               = drv[i].mem_wr;
      in_mem_rd[i]               = drv[i].mem_rd;
    end
  end

  task automatic check(input string tag, input logic [127:0] observed,
                       input logic [127:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic ex_mem_payload_t get_out(input int ch);
    ex_mem_payload_t p;
    p.result = out_result[ch*XLEN +: XLEN];
    p.pc     = out_pc[ch*XLEN +: XLEN];
    p.tag    = out_tag[ch*TAG_W +: TAG_W];
    p.op     = out_op[ch*OP_W +: OP_W];
    p.mem_wr = out_mem_wr[ch];
    p.mem_rd = out_mem_rd[ch];
    return p;
  endfunction

  // Scoreboard: on the falling edge, compare the DUT against the reference
  // FIFO, then record what the coming rising edge will accept and pop.
  always @(negedge clk) begin
    if (!rstn) begin
      for (int c = 0; c < NCH; c++) sb[c].delete();
    end else begin
      logic any;
      any = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        any = any | (sb[c].size() != 0);
        check($sformatf("out_valid[%0d]", c), 128'(out_valid[c]), 128'(sb[c].size() != 0));
        check($sformatf("in_ready[%0d]", c), 128'(in_ready[c]), 128'(sb[c].size() < 2));
        if (sb[c].size() != 0)
          check($sformatf("payload[%0d]", c), 128'(get_out(c)), 128'(sb[c][0]));
      end
      check("busy", 128'(busy), 128'(any));
      if (flush) begin
        for (int c = 0; c < NCH; c++) sb[c].delete();
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (out_valid[c] && out_ready[c] && sb[c].size() != 0) begin
            void'(sb[c].pop_front());
            pops[c]++;
          end
          if (in_valid[c] && in_ready[c]) sb[c].push_back(drv[c]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_drv(input int ch, input logic [31:0] result,
                         input logic [31:0] pc, input logic [5:0] tag);
    drv[ch].result = result;
    drv[ch].pc     = pc;
    drv[ch].tag    = tag;
    drv[ch].op     = tag[3:0];
    drv[ch].mem_wr = result[0];
    drv[ch].mem_rd = result[1];
  endtask

  // Hold one beat valid until an edge at which in_ready was high.
  task automatic push_wait(input int ch, input logic [31:0] result,
                           input logic [31:0] pc, input logic [5:0] tag);
    logic r;
    bit   done;
    done = 1'b0;
    set_drv(ch, result, pc, tag);
    in_valid[ch] = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      #1 r = in_ready[ch];
      @(posedge clk);
      #2;
      done = r;
    end
    in_valid[ch] = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $error("FAIL push_timeout ch%0d: observed no accept expected accept within 20 cycles", ch);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    vectors     = 0;
    miscompares = 0;
    for (int c = 0; c < NCH; c++) begin
      pops[c] = 0;
      set_drv(c, 32'h0, 32'h0, 6'h0);
    end
    rstn      = 1'b0;
    flush     = 1'b0;
    in_valid  = '1;
    out_ready = '0;

    // Reset state with upstream valid asserted.
    #7;
    check("rst_out_valid", 128'(out_valid), 128'(4'b0000));
    check("rst_in_ready", 128'(in_ready), 128'(4'b1111));
    check("rst_out_result", 128'(out_result), 128'(0));
    check("rst_out_pc", 128'(out_pc), 128'(0));
    check("rst_out_tag", 128'(out_tag), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    repeat (2) cyc();

    // First beat after reset: latency 1.
    rstn     = 1'b1;
    in_valid = 4'b0001;
    set_drv(0, 32'hDEAD_BEEF, 32'h40, 6'd5);
    cyc();
    in_valid = '0;
    check("first_valid", 128'(out_valid[0]), 128'(1));
    check("first_result", 128'(out_result[31:0]), 128'(32'hDEAD_BEEF));
    check("first_tag", 128'(out_tag[5:0]), 128'(6'd5));
    out_ready[0] = 1'b1;
    repeat (2) cyc();

    // Streaming on ch1.
    out_ready[1] = 1'b1;
    p = pops[1];
    for (int k = 0; k < 8; k++) begin
      set_drv(1, 32'h1000 + k, 32'h100 + 4 * k, 6'(k));
      in_valid[1] = 1'b1;
      #1 check("stream_in_ready", 128'(in_ready[1]), 128'(1));
      cyc();
    end
    in_valid[1] = 1'b0;
    repeat (2) cyc();
    check("stream_pops", 128'(pops[1] - p), 128'(8));

    // Back-pressure on ch2.
    out_ready[2] = 1'b0;
    p = pops[2];
    push_wait(2, 32'h11, 32'h200, 6'd1);
    push_wait(2, 32'h22, 32'h204, 6'd2);
    #1 check("bp_in_ready_low", 128'(in_ready[2]), 128'(0));
    set_drv(2, 32'h33, 32'h208, 6'd3);
    in_valid[2] = 1'b1;
    repeat (3) begin
      cyc();
      check("bp_hold_result", 128'(out_result[2*XLEN +: XLEN]), 128'(32'h11));
    end
    out_ready[2] = 1'b1;
    push_wait(2, 32'h33, 32'h208, 6'd3);
    repeat (3) cyc();
    check("bp_pops", 128'(pops[2] - p), 128'(3));

    // Flush with ch0 and ch3 full plus a concurrent accept on ch1.
    out_ready[0] = 1'b0;
    out_ready[3] = 1'b0;
    push_wait(0, 32'hA0, 32'h300, 6'd10);
    push_wait(0, 32'hA1, 32'h304, 6'd11);
    push_wait(3, 32'hB0, 32'h400, 6'd20);
    push_wait(3, 32'hB1, 32'h404, 6'd21);
    set_drv(1, 32'h999, 32'h500, 6'd30);
    in_valid = 4'b0011;
    flush    = 1'b1;
    cyc();
    flush    = 1'b0;
    in_valid = '0;
    check("flush_out_valid", 128'(out_valid), 128'(4'b0000));
    check("flush_in_ready", 128'(in_ready), 128'(4'b1111));
    check("flush_busy", 128'(busy), 128'(0));
    repeat (3) begin
      cyc();
      check("flush_no_ghost", 128'(out_valid), 128'(4'b0000));
    end

    // Independence: ch0 fully stalled while ch1 streams.
    out_ready[0] = 1'b0;
    push_wait(0, 32'hC0, 32'h600, 6'd40);
    push_wait(0, 32'hC1, 32'h604, 6'd41);
    out_ready[1] = 1'b1;
    p = pops[1];
    for (int k = 0; k < 4; k++) begin
      set_drv(1, 32'hD0 + k, 32'h700 + 4 * k, 6'(50 + k));
      in_valid[1] = 1'b1;
      #1 check("indep_in_ready1", 128'(in_ready[1]), 128'(1));
      check("indep_ch0_result", 128'(out_result[31:0]), 128'(32'hC0));
      cyc();
    end
    in_valid[1] = 1'b0;
    cyc();
    check("indep_pops", 128'(pops[1] - p), 128'(4));
    check("indep_ch0_valid", 128'(out_valid[0]), 128'(1));
    check("indep_ch0_ready", 128'(in_ready[0]), 128'(0));

    // Async reset mid-cycle with traffic in flight.
    out_ready[2] = 1'b0;
    push_wait(2, 32'hE0, 32'h800, 6'd60);
    set_drv(3, 32'hE1, 32'h900, 6'd61);
    in_valid[3] = 1'b1;
    #1 rstn = 1'b0;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(4'b0000));
    check("arst_in_ready", 128'(in_ready), 128'(4'b1111));
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_out_result", 128'(out_result), 128'(0));
    check("arst_out_tag", 128'(out_tag), 128'(0));
    cyc();
    rstn      = 1'b1;
    in_valid  = 4'b0001;
    out_ready = '1;
    set_drv(0, 32'hF00D, 32'hA00, 6'd62);
    cyc();
    in_valid = '0;
    check("post_rst_valid", 128'(out_valid), 128'(4'b0001));
    check("post_rst_result", 128'(out_result[31:0]), 128'(32'hF00D));
    repeat (3) cyc();
    check("final_busy", 128'(busy), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
